learn_cycle_sequencer: RTL and testbench

//  Sequences one node decision cycle through N_STAGES chained sub-blocks (e.g. nexthop search,

---
 rtl/learn_cycle_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_learn_cycle_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/learn_cycle_sequencer.sv
// Steps one decision cycle through stages 0..N_STAGES-1 (en, start, wait for done); 2 cycles + stage run time per stage, plus 1 FIN cycle.
// Holds in WAIT until the current stage reports done; the shared write port follows the current stage. `LCS_WATCHDOG_EN adds a per-stage timeout abort.
module learn_cycle_sequencer #(
  parameter  int N_STAGES = 4,
  parameter  int ADDR_W   = 11,
  parameter  int DATA_W   = 16,
  parameter  int TIMEOUT  = 255,
  localparam int CUR_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                       clock,
  input  logic                       nrst,
  input  logic                       go_i,
  input  logic [N_STAGES-1:0]        stg_done_i,
  input  logic [N_STAGES-1:0]        stg_wr_en_i,
  input  logic [N_STAGES*ADDR_W-1:0] stg_addr_i,
  input  logic [N_STAGES*DATA_W-1:0] stg_data_i,
  output logic [N_STAGES-1:0]        stg_en_o,
  output logic [N_STAGES-1:0]        stg_start_o,
  output logic                       mem_wr_en_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_data_o,
  output logic                       busy_o,
  output logic                       cycle_done_o,
  output logic                       timeout_err_o,
  output logic [CUR_W-1:0]           err_stage_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_KICK = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [CUR_W-1:0] LAST_STG = CUR_W'(N_STAGES - 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("learn_cycle_sequencer: TIMEOUT must be at least 1");
  end

  logic [2:0]          state_q, state_d;
  logic [CUR_W-1:0]    cur_q, cur_d;
  logic [N_STAGES-1:0] stg_en_q, stg_en_d;
  logic [N_STAGES-1:0] stg_start_q, stg_start_d;
  logic                cycle_done_q, cycle_done_d;
  logic                cur_done;
  logic                cur_last;

`ifdef LCS_WATCHDOG_EN
  localparam int WDOG_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              terr_q, terr_d;
  logic [CUR_W-1:0]  estage_q, estage_d;
`endif

  function automatic logic [N_STAGES-1:0] onehot(input logic [CUR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign cur_done = stg_done_i[cur_q];
  assign cur_last = (cur_q == LAST_STG);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    stg_en_d     = '0;
    stg_start_d  = '0;
    cycle_done_d = 1'b0;
`ifdef LCS_WATCHDOG_EN
    wdog_d       = wdog_q;
    terr_d       = terr_q;
    estage_d     = estage_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          state_d  = S_ARM;
          cur_d    = '0;
          stg_en_d = onehot('0);
`ifdef LCS_WATCHDOG_EN
          terr_d   = 1'b0;
          estage_d = '0;
`endif
        end
      end
      S_ARM: begin
        state_d     = S_KICK;
        stg_start_d = onehot(cur_q);
      end
      S_KICK: begin
        state_d = S_WAIT;
`ifdef LCS_WATCHDOG_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        // done is only trusted here: a stage's done from its previous run is dropped by its en
        if (cur_done) begin
          if (cur_last) begin
            state_d      = S_FIN;
            cycle_done_d = 1'b1;
          end else begin
            state_d  = S_ARM;
            cur_d    = cur_q + CUR_W'(1);
            stg_en_d = onehot(cur_q + CUR_W'(1));
          end
        end
`ifdef LCS_WATCHDOG_EN
        else if (wdog_q == WDOG_LIMIT) begin
          state_d      = S_FIN;
          cycle_done_d = 1'b1;
          terr_d       = 1'b1;
          estage_d     = cur_q;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      S_FIN: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (nrst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      stg_en_q     <= '0;
      stg_start_q  <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      stg_en_q     <= stg_en_d;
      stg_start_q  <= stg_start_d;
      cycle_done_q <= cycle_done_d;
    end
  end

`ifdef LCS_WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (nrst) begin
      wdog_q   <= '0;
      terr_q   <= 1'b0;
      estage_q <= '0;
    end else begin
      wdog_q   <= wdog_d;
      terr_q   <= terr_d;
      estage_q <= estage_d;
    end
  end

  assign timeout_err_o = terr_q;
  assign err_stage_o   = estage_q;
`else
  assign timeout_err_o = 1'b0;
  assign err_stage_o   = '0;
`endif

  // Writes from any stage other than cur are dropped, never buffered.
  always_comb begin
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    if (state_q == S_KICK || state_q == S_WAIT) begin
      mem_wr_en_o = stg_wr_en_i[cur_q];
      mem_addr_o  = stg_addr_i[cur_q*ADDR_W +: ADDR_W];
      mem_data_o  = stg_data_i[cur_q*DATA_W +: DATA_W];
    end
  end

  assign stg_en_o     = stg_en_q;
  assign stg_start_o  = stg_start_q;
  assign cycle_done_o = cycle_done_q;
  assign busy_o       = (state_q != S_IDLE);

  a_en_start_excl: assert property (@(posedge clock) disable iff (nrst)
    !((|stg_en_q) && (|stg_start_q)));
  a_pulse_onehot: assert property (@(posedge clock) disable iff (nrst)
    $onehot0(stg_en_q) && $onehot0(stg_start_q));

endmodule

// File: tb/tb_learn_cycle_sequencer.sv
// Scoreboard bench for learn_cycle_sequencer: stage models answer en/start, expected pulse order and cycle lengths are queued at go.
// Define LCS_WATCHDOG_EN on both files to add the timeout scenarios (TIMEOUT=8).
module tb_learn_cycle_sequencer;
  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 16;
`ifdef LCS_WATCHDOG_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  localparam int EV_EN   = 32'h100;
  localparam int EV_ST   = 32'h200;
  localparam int EV_DONE = 32'h300;

  logic          clock       = 1'b0;
  logic          nrst        = 1'b1;
  logic          go_i        = 1'b0;
  logic [N-1:0]  stg_done_i  = '0;
  logic [N-1:0]  stg_wr_en_i = '0;
  logic [N*AW-1:0] stg_addr_i = '0;
  logic [N*DW-1:0] stg_data_i = '0;
  logic [N-1:0]  stg_en_o;
  logic [N-1:0]  stg_start_o;
  logic          mem_wr_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          busy_o;
  logic          cycle_done_o;
  logic          timeout_err_o;
  logic [1:0]    err_stage_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int go_cyc = 0;
  int exp_len = 0;
  int done_cnt = 0;
  logic       exp_terr = 1'b0;
  logic [1:0] exp_estage = 2'd0;
  int lat [N] = '{default: 3};
  int cnt [N] = '{default: 0};
  int exp_q [$];

  learn_cycle_sequencer #(.N_STAGES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clock(clock), .nrst(nrst), .go_i(go_i),
    .stg_done_i(stg_done_i), .stg_wr_en_i(stg_wr_en_i),
    .stg_addr_i(stg_addr_i), .stg_data_i(stg_data_i),
    .stg_en_o(stg_en_o), .stg_start_o(stg_start_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .cycle_done_o(cycle_done_o),
    .timeout_err_o(timeout_err_o), .err_stage_o(err_stage_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sb_pop(input int ev);
    if (exp_q.size() == 0) chk("sb_extra_event", ev, 32'hFFFF);
    else chk("sb_event", ev, exp_q.pop_front());
  endtask

  // Monitor pops the scoreboard; stage models answer en/start with done after lat cycles (lat 0 = never).
  always @(negedge clock) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) begin
        if (stg_en_o[i]) begin
          sb_pop(EV_EN + i);
          if (i == 0) chk("go_to_en0", cyc - go_cyc, 1);
        end
        if (stg_start_o[i]) sb_pop(EV_ST + i);
      end
      if ((|stg_en_o) || (|stg_start_o)) chk("pulse_onehot", $countones({stg_en_o, stg_start_o}), 1);
      if (cycle_done_o) begin
        done_cnt++;
        sb_pop(EV_DONE);
        chk("cycle_len", cyc - go_cyc, exp_len);
        chk("timeout_err", timeout_err_o, exp_terr);
        chk("err_stage", err_stage_o, exp_estage);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (stg_en_o[i]) stg_done_i[i] = 1'b0;
      if (stg_start_o[i]) cnt[i] = lat[i];
      else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) stg_done_i[i] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic push_cycle(input int abort_stg);
    int len;
    len = 1;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(EV_EN + i);
      exp_q.push_back(EV_ST + i);
      if (i == abort_stg) begin
        len += 2 + TMO + 1;
        break;
      end
      len += 2 + lat[i];
    end
    exp_q.push_back(EV_DONE);
    exp_len    = len;
    exp_terr   = (abort_stg >= 0);
    exp_estage = (abort_stg >= 0) ? 2'(abort_stg) : 2'd0;
  endtask

  task automatic pulse_go();
    go_i   = 1'b1;
    go_cyc = cyc;
    tick();
    go_i   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      tick();
      n++;
      if (cycle_done_o) seen = 1'b1;
    end
    chk("cycle_done_seen", seen, 1);
  endtask

  task automatic wait_start(input int s);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (stg_start_o[s]) seen = 1'b1;
    end
    chk("start_seen", seen, 1);
  endtask

  task automatic post_cycle(input int d0, input int n_done);
    tick();
    chk("idle_busy", busy_o, 0);
    chk("done_single_pulse", cycle_done_o, 0);
    chk("done_count", done_cnt - d0, n_done);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    // Reset state, with stray write requests present
    stg_wr_en_i = '1;
    stg_addr_i  = {N{11'h5A5}};
    stg_data_i  = {N{16'hA5A5}};
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_en", stg_en_o, 0);
    chk("rst_start", stg_start_o, 0);
    chk("rst_cycle_done", cycle_done_o, 0);
    chk("rst_timeout_err", timeout_err_o, 0);
    chk("rst_err_stage", err_stage_o, 0);
    chk("rst_mem_wr_en", mem_wr_en_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    stg_wr_en_i = '0;
    stg_addr_i  = '0;
    stg_data_i  = '0;
    nrst = 1'b0;
    repeat (2) tick();
    chk("idle_no_go_busy", busy_o, 0);

    // Every stage done 3 cycles after start: 4*(2+3)+1 = 21
    d0 = done_cnt;
    set_lat(3, 3, 3, 3);
    push_cycle(-1);
    pulse_go();
    chk("busy_after_go", busy_o, 1);
    wait_done();
    post_cycle(d0, 1);

    // Write port follows stage 2 only
    d0 = done_cnt;
    push_cycle(-1);
    pulse_go();
    wait_start(2);
    stg_addr_i[2*AW +: AW] = 11'h2;
    stg_data_i[2*DW +: DW] = 16'h1;
    stg_wr_en_i = 4'b1000;
    #1;
    chk("kick_other_wr_en", mem_wr_en_o, 0);
    chk("kick_addr", mem_addr_o, 11'h2);
    chk("kick_data", mem_data_o, 16'h1);
    tick();
    stg_addr_i[0 +: AW] = 11'h7FF;
    stg_data_i[0 +: DW] = 16'hBEEF;
    stg_wr_en_i = 4'b0101;
    #1;
    chk("wait_wr_en", mem_wr_en_o, 1);
    chk("wait_addr", mem_addr_o, 11'h2);
    chk("wait_data", mem_data_o, 16'h1);
    chk("wait_busy", busy_o, 1);
    tick();
    stg_wr_en_i = 4'b0001;
    #1;
    chk("noncur_wr_dropped", mem_wr_en_o, 0);
    stg_wr_en_i = '0;
    wait_done();
    post_cycle(d0, 1);
    stg_wr_en_i = '1;
    #1;
    chk("idle_mem_wr_en", mem_wr_en_o, 0);
    chk("idle_mem_addr", mem_addr_o, 0);
    chk("idle_mem_data", mem_data_o, 0);
    stg_wr_en_i = '0;
    stg_addr_i  = '0;
    stg_data_i  = '0;

    // Minimum cycle (13), stale done levels from the last run, go re-pulsed mid-cycle
    d0 = done_cnt;
    set_lat(1, 1, 1, 1);
    push_cycle(-1);
    pulse_go();
    repeat (4) tick();
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    wait_done();
    post_cycle(d0, 1);

    // go held high: second cycle starts on the IDLE cycle after FIN
    d0 = done_cnt;
    set_lat(2, 4, 1, 3);
    push_cycle(-1);
    push_cycle(-1);
    go_i   = 1'b1;
    go_cyc = cyc;
    wait_done();
    tick();
    chk("held_go_idle_busy", busy_o, 0);
    go_cyc = cyc;
    tick();
    go_i = 1'b0;
    chk("held_go_restart_busy", busy_o, 1);
    wait_done();
    post_cycle(d0, 2);

    // Reset during WAIT of stage 2: no cycle_done, straight to idle
    set_lat(3, 3, 3, 3);
    push_cycle(-1);
    pulse_go();
    wait_start(2);
    tick();
    nrst = 1'b1;
    tick();
    chk("midrst_busy", busy_o, 0);
    chk("midrst_en", stg_en_o, 0);
    chk("midrst_start", stg_start_o, 0);
    chk("midrst_cycle_done", cycle_done_o, 0);
    exp_q.delete();
    nrst = 1'b0;
    d0 = done_cnt;
    repeat (20) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_stays_idle", busy_o, 0);
    set_lat(3, 1, 2, 2);
    push_cycle(-1);
    pulse_go();
    wait_done();
    post_cycle(d0, 1);

`ifdef LCS_WATCHDOG_EN
    // Stage 1 never done: abort after TIMEOUT, stages 2 and 3 skipped
    d0 = done_cnt;
    set_lat(2, 0, 3, 3);
    push_cycle(1);
    pulse_go();
    wait_done();
    post_cycle(d0, 1);
    chk("terr_sticky", timeout_err_o, 1);
    chk("estage_sticky", err_stage_o, 1);

    // Done on the TIMEOUT cycle wins; error cleared by go
    d0 = done_cnt;
    set_lat(1, TMO + 1, 1, 1);
    push_cycle(-1);
    pulse_go();
    chk("terr_cleared_by_go", timeout_err_o, 0);
    chk("estage_cleared_by_go", err_stage_o, 0);
    wait_done();
    post_cycle(d0, 1);
`endif

    chk("sb_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
